// File: rtl/window_gen_pkg.sv
// -----------------------------------------------------------------------------
// window_gen_pkg
// Purpose : shared widths, default image geometry and the column-vector type
//           used by the 3x3 window generator, plus the window packing helper.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package window_gen_pkg;

    localparam int PIXEL_W        = 8;
    localparam int WIN_TAPS       = 9;
    localparam int WIN_W          = PIXEL_W * WIN_TAPS;
    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

    // One vertical slice of the window: top is the oldest row.
    typedef struct packed {
        logic [PIXEL_W-1:0] top;
        logic [PIXEL_W-1:0] mid;
        logic [PIXEL_W-1:0] bot;
    } col_vec_t;

    // Byte i of the window is row*3+col, row 0 = top, col 0 = oldest column.
    function automatic logic [WIN_W-1:0] pack_window(
        input col_vec_t c0,
        input col_vec_t c1,
        input col_vec_t c2
    );
        logic [WIN_W-1:0] w;
        w = '0;
        w[0*PIXEL_W +: PIXEL_W] = c0.top;
        w[1*PIXEL_W +: PIXEL_W] = c1.top;
        w[2*PIXEL_W +: PIXEL_W] = c2.top;
        w[3*PIXEL_W +: PIXEL_W] = c0.mid;
        w[4*PIXEL_W +: PIXEL_W] = c1.mid;
        w[5*PIXEL_W +: PIXEL_W] = c2.mid;
        w[6*PIXEL_W +: PIXEL_W] = c0.bot;
        w[7*PIXEL_W +: PIXEL_W] = c1.bot;
        w[8*PIXEL_W +: PIXEL_W] = c2.bot;
        return w;
    endfunction

endpackage

// File: rtl/window_gen_if.sv
// -----------------------------------------------------------------------------
// window_gen_if
// Purpose : valid-qualified pixel/window stream bundle. No ready signal: the
//           producer asserts valid for one cycle per beat and the consumer
//           must take the beat in that same cycle (no backpressure).
// Ports   : data  - payload, W bits
//           valid - qualifies data for the current cycle
// Modports: master drives data/valid, slave receives them.
// -----------------------------------------------------------------------------
interface window_gen_if
    import window_gen_pkg::*;
#(
    parameter int W = PIXEL_W
);
    logic [W-1:0] data;
    logic         valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Purpose : single-clock DEPTH x PIXEL_W row memory. Read is combinational on
//           the write address, so a same-cycle write sees the old contents
//           (read-before-write). Contents are not reset.
// Ports   : i_clk   - clock
//           i_wr_en - write strobe
//           i_addr  - shared read/write address
//           i_wdata - write data
//           o_rdata - contents at i_addr before this cycle's write
// -----------------------------------------------------------------------------
module line_buffer
    import window_gen_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_addr,
    input  logic [PIXEL_W-1:0] i_wdata,
    output logic [PIXEL_W-1:0] o_rdata
);

    logic [PIXEL_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_gen.sv
// -----------------------------------------------------------------------------
// window_gen
// Purpose : builds 3x3 pixel windows from a raster pixel stream using two line
//           buffers and a column shift register. A window is emitted (one-cycle
//           strobe) one cycle after each accepted pixel at row>=2, col>=2.
// Ports   : i_clk              - clock, rising edge
//           i_rst_n            - asynchronous active-low reset
//           i_pixel_data       - raster-order pixel
//           i_pixel_data_valid - accept strobe for i_pixel_data
//           o_pixel_data       - 72-bit window, byte i = row*3+col
//           o_pixel_data_valid - one-cycle new-window strobe
// -----------------------------------------------------------------------------
module window_gen
    import window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PIXEL_W-1:0] i_pixel_data,
    input  logic               i_pixel_data_valid,
    output logic [WIN_W-1:0]   o_pixel_data,
    output logic               o_pixel_data_valid
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [PIXEL_W-1:0] w_lb_a_rdata;
    logic [PIXEL_W-1:0] w_lb_b_rdata;
    col_vec_t           w_new_col;
    logic               w_win_ok;

    // Column history: r_sr[1] is the newest stored column, r_sr[0] the one
    // before it. The incoming column vector is the third (newest) column.
    col_vec_t           r_sr [2];

    // LB_A holds row-2, LB_B holds row-1. Each accept shifts a column down.
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_a (
        .i_clk   (i_clk),
        .i_wr_en (i_pixel_data_valid),
        .i_addr  (r_col),
        .i_wdata (w_lb_b_rdata),
        .o_rdata (w_lb_a_rdata)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_b (
        .i_clk   (i_clk),
        .i_wr_en (i_pixel_data_valid),
        .i_addr  (r_col),
        .i_wdata (i_pixel_data),
        .o_rdata (w_lb_b_rdata)
    );

    assign w_new_col.top = w_lb_a_rdata;
    assign w_new_col.mid = w_lb_b_rdata;
    assign w_new_col.bot = i_pixel_data;

    // Gating on row>=2 and col>=2 keeps every emitted window inside one
    // frame and one row, and keeps stale line-buffer data off the output.
    assign w_win_ok = (r_row >= RW'(2)) && (r_col >= CW'(2));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pixel_data_valid) begin
            if (r_col == CW'(IMG_WIDTH - 1)) begin
                r_col <= '0;
                if (r_row == RW'(IMG_HEIGHT - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr[0] <= '0;
            r_sr[1] <= '0;
        end else if (i_pixel_data_valid) begin
            r_sr[0] <= r_sr[1];
            r_sr[1] <= w_new_col;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
        end else begin
            o_pixel_data_valid <= i_pixel_data_valid && w_win_ok;
            if (i_pixel_data_valid && w_win_ok) begin
                o_pixel_data <= pack_window(r_sr[0], r_sr[1], w_new_col);
            end
        end
    end

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;
    import window_gen_pkg::*;

    logic i_clk;
    logic i_rst_n;

    window_gen_if #(.W(PIXEL_W)) in_if ();
    window_gen_if #(.W(WIN_W))   out_if ();

    window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_pixel_data       (in_if.data),
        .i_pixel_data_valid (in_if.valid),
        .o_pixel_data       (out_if.data),
        .o_pixel_data_valid (out_if.valid)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int fails;
    logic [WIN_W-1:0] exp_tab [4];
    logic [WIN_W-1:0] last_win;

    function automatic logic [WIN_W-1:0] mk9(
        input int b0, input int b1, input int b2,
        input int b3, input int b4, input int b5,
        input int b6, input int b7, input int b8
    );
        logic [WIN_W-1:0] w;
        w = '0;
        w[0*8 +: 8] = b0[7:0]; w[1*8 +: 8] = b1[7:0]; w[2*8 +: 8] = b2[7:0];
        w[3*8 +: 8] = b3[7:0]; w[4*8 +: 8] = b4[7:0]; w[5*8 +: 8] = b5[7:0];
        w[6*8 +: 8] = b6[7:0]; w[7*8 +: 8] = b7[7:0]; w[8*8 +: 8] = b8[7:0];
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] add_off(input logic [WIN_W-1:0] w, input int off);
        logic [WIN_W-1:0] r;
        logic [7:0] o8;
        o8 = off[7:0];
        r = w;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = w[i*8 +: 8] + o8;
        return r;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, then observe the registered output one cycle later,
    // followed by 'idle' empty cycles during which nothing may change.
    task automatic push(input int p, input int idle, input bit ev, input logic [WIN_W-1:0] ed, input string tag);
        in_if.data  = p[7:0];
        in_if.valid = 1'b1;
        @(posedge i_clk); #1;
        in_if.valid = 1'b0;
        chk_bit({tag, "_valid"}, out_if.valid, ev);
        if (ev) last_win = ed;
        chk_win({tag, "_data"}, out_if.data, last_win);
        for (int k = 0; k < idle; k++) begin
            @(posedge i_clk); #1;
            chk_bit({tag, "_idle_valid"}, out_if.valid, 1'b0);
            chk_win({tag, "_idle_data"}, out_if.data, last_win);
        end
    endtask

    // Stream one 4x4 frame with pixel values k+off, k = 1..16.
    task automatic run_frame(input int off, input int max_idle, input string tag);
        bit ev;
        logic [WIN_W-1:0] ed;
        for (int k = 1; k <= 16; k++) begin
            ev = 1'b1;
            case (k)
                11: ed = add_off(exp_tab[0], off);
                12: ed = add_off(exp_tab[1], off);
                15: ed = add_off(exp_tab[2], off);
                16: ed = add_off(exp_tab[3], off);
                default: begin ev = 1'b0; ed = '0; end
            endcase
            push(k + off, $urandom_range(0, max_idle), ev, ed, $sformatf("%s_p%0d", tag, k));
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        last_win = '0;
        exp_tab[0] = mk9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        exp_tab[1] = mk9(2, 3, 4, 6, 7, 8, 10, 11, 12);
        exp_tab[2] = mk9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        exp_tab[3] = mk9(6, 7, 8, 10, 11, 12, 14, 15, 16);

        in_if.data  = '0;
        in_if.valid = 1'b0;
        i_rst_n     = 1'b0;
        #2;
        chk_bit("reset_valid", out_if.valid, 1'b0);
        chk_win("reset_data", out_if.data, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // frame 1 back-to-back, then frame 2 directly following
        run_frame(0, 0, "f1");
        run_frame(16, 0, "f2");

        // partial frame, then asynchronous mid-cycle reset after pixel 7
        for (int k = 1; k <= 7; k++) push(k + 40, 0, 1'b0, '0, $sformatf("part_p%0d", k));
        #3;
        i_rst_n = 1'b0;
        #1;
        chk_bit("async_rst_valid", out_if.valid, 1'b0);
        last_win = '0;
        chk_win("async_rst_data", out_if.data, '0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // re-stream after reset, then with random idle gaps
        run_frame(0, 0, "rst_f");
        run_frame(0, 3, "idle_f");

        repeat (3) begin
            @(posedge i_clk); #1;
            chk_bit("tail_valid", out_if.valid, 1'b0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per image row (min 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, rows per frame (min 3).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data  input  8  raster-order pixel, row-major, left to right.
REQ-006 SHALL have port i_pixel_data_valid  input  1  qualifies i_pixel_data; one pixel accepted per high cycle.
REQ-007 SHALL have port o_pixel_data  output  72  3x3 window; byte i = bits [i*8+:8], i = row*3+col, row 0 = top (oldest), col 0 = left (oldest), byte 4 = centre.
REQ-008 SHALL have port o_pixel_data_valid  output  1  one-cycle strobe marking a new window on o_pixel_data.

Function
REQ-009 SHALL accept a pixel on every cycle with i_pixel_data_valid=1; no backpressure, no ready signal.
REQ-010 SHALL hold column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), both advancing only on accepted pixels.
REQ-011 SHALL wrap col to 0 after IMG_WIDTH-1 and increment row; SHALL wrap row to 0 after IMG_HEIGHT-1 (frame boundary).
REQ-012 SHALL keep two line buffers of IMG_WIDTH x 8: LB_A = row-2, LB_B = row-1, addressed by col.
REQ-013 On accept of pixel p at col c: column vector = {top=LB_A[c], mid=LB_B[c], bot=p}; LB_A[c] <= LB_B[c]; LB_B[c] <= p (read-before-write, same cycle).
REQ-014 SHALL hold a 3-column shift register of column vectors; newest column = col 2 of window.
REQ-015 SHALL register o_pixel_data and o_pixel_data_valid; latency exactly 1 cycle from accepting the completing pixel.
REQ-016 SHALL assert o_pixel_data_valid for one cycle iff accepted pixel had row>=2 and col>=2; else 0 next cycle.
REQ-017 SHALL hold o_pixel_data unchanged when no window is produced.
REQ-018 SHALL never form a window spanning a row boundary or a frame boundary (guaranteed by REQ-016 gating).
REQ-019 Idle cycles (valid=0) inside a row SHALL not change counters, buffers, or produced windows.
REQ-020 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.

Reset
REQ-021 On i_rst_n=0: col=0, row=0, shift register=0, o_pixel_data=72'd0, o_pixel_data_valid=0, immediately (asynchronous).
REQ-022 Line buffer memories SHALL NOT be reset; stale contents never reach a valid output (REQ-016).
REQ-023 Reset mid-frame SHALL discard partial frame; first pixel after release is row 0, col 0.

Structure
REQ-024 Shared package SHALL hold PIXEL_W=8, WIN_TAPS=9, WIN_W=72, default IMG_WIDTH/IMG_HEIGHT.
REQ-025 SHALL instantiate sub-module line_buffer (single-clock IMG_WIDTH x 8 memory, registered-address-free read-before-write, one write port) twice.
REQ-026 o_pixel_data/o_pixel_data_valid SHALL drive conv's i_pixel_data/i_pixel_data_valid directly, no glue.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4)
REQ-027 Stream 1..16 back-to-back -> first valid the cycle after pixel 11; bytes 0..8 = 1,2,3,5,6,7,9,10,11.
REQ-028 Same stream -> exactly 4 valid strobes, windows completing at pixels 11,12,15,16; after 12: 2,3,4,6,7,8,10,11,12; no strobe after 13 or 14.
REQ-029 Same stream with 0-3 random idle cycles between pixels -> identical window sequence, each 1 cycle after its completing pixel.
REQ-030 Second frame 17..32 following first -> no strobe for pixels 17..26; first window after 27 = 17,18,19,21,22,23,25,26,27.
REQ-031 Assert i_rst_n=0 after pixel 7 (asynchronously, mid-cycle) -> outputs 0 immediately; re-stream 1..16 -> results equal REQ-027/REQ-028.
